// File: rtl/framer_pkg.sv
// framer_pkg: types, constants and helpers for fwft_byte_framer.
//   state_t   : framer FSM state encoding (IDLE, HDR, SEQ, PAY, CSUM)
//   CRC8_POLY : CRC-8 generator polynomial x^8 + x^2 + x + 1
//   crc8_byte : folds one byte into a running CRC-8 (MSB-first, unreflected)
//   sum8_byte : folds one byte into a running 8-bit additive checksum
package framer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    PAY  = 3'd3,
    CSUM = 3'd4
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One byte of CRC-8: xor the byte into the register, then shift out 8 bits.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  // One byte of the additive checksum (wraps mod 256).
  function automatic logic [7:0] sum8_byte(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/framer_csum.sv
// framer_csum: frame checksum accumulator.
// Build option: FRAMER_CRC8_EN defined -> CRC-8 (poly 0x07, init 0x00);
//               undefined                -> 8-bit additive sum.
// Ports:
//   sys_clk : clock
//   rstn    : synchronous active-low reset (accumulator -> 0)
//   clr     : restart the checksum from its initial value and fold in din
//   upd     : fold din into the running checksum
//   din     : byte to fold in
//   csum    : current checksum (registered)
module framer_csum
  import framer_pkg::*;
(
  input  logic       sys_clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       upd,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  logic [7:0] csum_r;
  logic [7:0] base_s;
  logic [7:0] next_s;

  // Select the starting value and apply the configured byte fold.
  always_comb begin
    base_s = csum_r;
    next_s = csum_r;
    if (clr) begin
      base_s = 8'h00;
    end else begin
      base_s = csum_r;
    end
    if (clr || upd) begin
`ifdef FRAMER_CRC8_EN
      next_s = crc8_byte(base_s, din);
`else
      next_s = sum8_byte(base_s, din);
`endif
    end else begin
      next_s = csum_r;
    end
  end

  // Checksum register.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      csum_r <= 8'h00;
    end else begin
      csum_r <= next_s;
    end
  end

  assign csum = csum_r;

endmodule

// File: rtl/fwft_byte_framer.sv
// fwft_byte_framer: pops bytes from a first-word-fall-through FIFO and emits
// fixed-length frames {HDR_BYTE, seq, PKT_LEN payload bytes, checksum} on a
// valid/ready byte stream. A frame only starts once a whole payload is
// buffered, so the payload never bubbles because of the FIFO.
// Build option: FRAMER_CRC8_EN selects a CRC-8 checksum instead of a sum.
// Ports:
//   sys_clk, rstn            : clock, synchronous active-low reset
//   enable                   : allows new frames to start
//   fifo_dout/empty/rd_count : FIFO head byte, empty flag, occupancy
//   fifo_rd_en               : FIFO pop strobe (combinational)
//   m_data/m_valid/m_last    : output byte stream (registered)
//   m_ready                  : sink ready
//   busy                     : FSM not idle
//   frame_cnt                : completed frames (wrapping)
module fwft_byte_framer
  import framer_pkg::*;
#(
  parameter int         PKT_LEN  = 16,
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         CNT_W    = 8
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] fifo_rd_count,
  output logic             fifo_rd_en,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] PKT_LEN_CNT = CNT_W'(PKT_LEN);
  localparam logic [7:0]       LAST_IDX    = 8'(PKT_LEN - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  seq_r;
  logic [7:0]  byte_idx_r;
  logic [15:0] frame_cnt_r;
  logic [7:0]  m_data_r;
  logic        m_valid_r;
  logic        m_last_r;

  logic        slot_free_s;
  logic        pop_s;
  logic        load_s;
  logic [7:0]  load_data_s;
  logic        load_last_s;
  logic        csum_clr_s;
  logic        csum_upd_s;
  logic [7:0]  csum_din_s;
  logic        seq_inc_s;
  logic        idx_inc_s;
  logic        idx_clr_s;
  logic [7:0]  csum_s;

  // The output slot can take a new byte when empty or being drained this cycle.
  assign slot_free_s = !m_valid_r || m_ready;

  // Next-state and per-cycle control; every transition waits for a free slot.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    load_data_s = 8'h00;
    load_last_s = 1'b0;
    csum_clr_s  = 1'b0;
    csum_upd_s  = 1'b0;
    csum_din_s  = 8'h00;
    seq_inc_s   = 1'b0;
    idx_inc_s   = 1'b0;
    idx_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && (fifo_rd_count >= PKT_LEN_CNT) && slot_free_s) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = HDR_BYTE;
          state_nxt_s = SEQ;
        end else begin
          state_nxt_s = HDR;
        end
      end
      SEQ: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = seq_r;
          csum_clr_s  = 1'b1;
          csum_din_s  = seq_r;
          state_nxt_s = PAY;
        end else begin
          state_nxt_s = SEQ;
        end
      end
      PAY: begin
        // Pop is gated by rstn so the FIFO is never drained during reset.
        if (rstn && !fifo_empty && slot_free_s) begin
          pop_s       = 1'b1;
          load_s      = 1'b1;
          load_data_s = fifo_dout;
          csum_upd_s  = 1'b1;
          csum_din_s  = fifo_dout;
          if (byte_idx_r == LAST_IDX) begin
            idx_clr_s   = 1'b1;
            state_nxt_s = CSUM;
          end else begin
            idx_inc_s   = 1'b1;
            state_nxt_s = PAY;
          end
        end else begin
          state_nxt_s = PAY;
        end
      end
      CSUM: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = csum_s;
          load_last_s = 1'b1;
          seq_inc_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CSUM;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output byte register: loads only into a free slot, otherwise holds.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      m_data_r  <= 8'h00;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (slot_free_s) begin
      m_valid_r <= load_s;
      m_last_r  <= load_s && load_last_s;
      if (load_s) begin
        m_data_r <= load_data_s;
      end
    end
  end

  // Sequence number, payload index and completed-frame counter.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      seq_r       <= 8'h00;
      byte_idx_r  <= 8'h00;
      frame_cnt_r <= 16'h0000;
    end else begin
      if (seq_inc_s) begin
        seq_r       <= seq_r + 8'd1;
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (idx_clr_s) begin
        byte_idx_r <= 8'h00;
      end else if (idx_inc_s) begin
        byte_idx_r <= byte_idx_r + 8'd1;
      end
    end
  end

  framer_csum u_csum (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .clr     (csum_clr_s),
    .upd     (csum_upd_s),
    .din     (csum_din_s),
    .csum    (csum_s)
  );

  assign fifo_rd_en = pop_s;
  assign m_data     = m_data_r;
  assign m_valid    = m_valid_r;
  assign m_last     = m_last_r;
  assign busy       = (state_r != IDLE);
  assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_fwft_byte_framer.sv
// Testbench for fwft_byte_framer: FIFO model, frame-level reference model
// feeding an expected-byte queue, and an independent stream monitor.
module tb_fwft_byte_framer;

  localparam int PKT_LEN = 16;
  localparam int CNT_W   = 8;

  logic             sys_clk = 1'b0;
  logic             rstn    = 1'b0;
  logic             enable  = 1'b0;
  logic             m_ready = 1'b0;
  logic [7:0]       fifo_dout;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_rd_count;
  logic             fifo_rd_en;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             busy;
  logic [15:0]      frame_cnt;

  fwft_byte_framer #(.PKT_LEN(PKT_LEN), .HDR_BYTE(8'hA5), .CNT_W(CNT_W)) dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .enable        (enable),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_count (fifo_rd_count),
    .fifo_rd_en    (fifo_rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- FWFT FIFO model ----------------
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush_req = 1'b0;

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_rd_count = CNT_W'(wr_ptr - rd_ptr);
  assign fifo_dout     = mem[rd_ptr[11:0]];

  always @(posedge sys_clk) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [8:0] exp_q [$];    // {last, data}
  logic [7:0] pend_q [$];   // bytes in FIFO not yet assigned to a frame
  logic [7:0] seq_m = 8'h00;
  logic [7:0] last_exp_csum;
  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] frame_check(input logic [7:0] s, input logic [7:0] pl [$]);
    logic [7:0] msg [$];
    logic [7:0] r;
    int sum;
    msg = pl;
    msg.push_front(s);
`ifdef FRAMER_CRC8_EN
    // Polynomial long division over the message bit stream, MSB first.
    r = 8'h00;
    foreach (msg[k]) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = r[7] ^ msg[k][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
`else
    sum = 0;
    foreach (msg[k]) sum = sum + int'(msg[k]);
    r = 8'(sum % 256);
`endif
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[11:0]] = b;
    wr_ptr = wr_ptr + 1;
    pend_q.push_back(b);
  endtask

  task automatic emit_frame();
    logic [7:0] pl [$];
    for (int i = 0; i < PKT_LEN; i++) pl.push_back(pend_q.pop_front());
    last_exp_csum = frame_check(seq_m, pl);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, seq_m});
    foreach (pl[i]) exp_q.push_back({1'b0, pl[i]});
    exp_q.push_back({1'b1, last_exp_csum});
    seq_m = seq_m + 8'd1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int         acc_cnt = 0;
  int         pop_cnt = 0;
  int         run = 0, gap = 0, last_run = 0, last_gap = 0;
  logic [7:0] csum_hist [$];
  logic       stall_prev = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  always @(negedge sys_clk) begin
    logic [8:0] e;
    if (rstn) begin
      if (fifo_rd_en) begin
        pop_cnt = pop_cnt + 1;
        checks  = checks + 1;
        if (fifo_empty) begin
          errors = errors + 1;
          $display("FAIL pop_when_empty: got rd_en=1 with empty=1, expected no pop");
        end
      end
      if (stall_prev) begin
        checks = checks + 1;
        if (!m_valid || m_data !== hold_data || m_last !== hold_last) begin
          errors = errors + 1;
          $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, expected v=1 d=%02h l=%0b",
                   m_valid, m_data, m_last, hold_data, hold_last);
        end
      end
      if (m_valid && m_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_byte: got d=%02h l=%0b, expected no output", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            errors = errors + 1;
            $display("FAIL stream_byte #%0d: got d=%02h l=%0b, expected d=%02h l=%0b",
                     acc_cnt, m_data, m_last, e[7:0], e[8]);
          end
        end
        acc_cnt = acc_cnt + 1;
        if (m_last) csum_hist.push_back(m_data);
      end
      if (m_valid) begin
        if (run == 0) last_gap = gap;
        gap = 0;
        run = run + 1;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        gap = gap + 1;
      end
      stall_prev = m_valid && !m_ready;
      hold_data  = m_data;
      hold_last  = m_last;
    end else begin
      stall_prev = 1'b0;
      run = 0;
      gap = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (toggle) m_ready = ~m_ready;
      if (exp_q.size() == 0 && !m_valid && !busy) begin
        ok = 1;
        break;
      end
    end
    m_ready = 1'b1;
    chk("drain_timeout", ok, 1);
    tick();
  endtask

  task automatic wait_acc(input int base, input int n, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (acc_cnt - base >= n) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("reach_byte_timeout", ok, 1);
  endtask

  initial begin
    int pop_base;
    int acc_base;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    rstn = 1'b1;
    tick();

    // Test 1: 0x01..0x10, stream A5,00,01..10,csum
    for (int i = 1; i <= PKT_LEN; i++) push_byte(8'(i));
    emit_frame();
    pop_base = pop_cnt;
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_drain(200, 1'b0);
    chk("t1_frame_cnt", int'(frame_cnt), 1);
    chk("t1_pops", pop_cnt - pop_base, PKT_LEN);
    chk("t1_valid_run", last_run, PKT_LEN + 3);
`ifndef FRAMER_CRC8_EN
    chk("t1_csum", int'(csum_hist[0]), 8'h88);
`endif

    // Test 2: 15 bytes never start a frame; then 32 buffered with m_ready toggling
    for (int i = 0; i < PKT_LEN - 1; i++) push_byte(8'($urandom_range(0, 255)));
    pop_base = pop_cnt;
    repeat (30) tick();
    chk("t2_idle_busy", int'(busy), 0);
    chk("t2_idle_valid", int'(m_valid), 0);
    chk("t2_idle_pops", pop_cnt - pop_base, 0);
    for (int i = 0; i < PKT_LEN + 1; i++) push_byte(8'($urandom_range(0, 255)));
    emit_frame();
    emit_frame();
    wait_drain(400, 1'b1);
    chk("t2_frame_cnt", int'(frame_cnt), 3);

    // Test 3: enable dropped during payload; second frame must not start
    for (int i = 0; i < 2 * PKT_LEN; i++) push_byte(8'($urandom_range(0, 255)));
    emit_frame();
    acc_base = acc_cnt;
    wait_acc(acc_base, 7, 200);
    enable = 1'b0;
    wait_drain(200, 1'b0);
    repeat (40) tick();
    chk("t3_frame_cnt", int'(frame_cnt), 4);
    chk("t3_busy", int'(busy), 0);
    chk("t3_fifo_left", int'(fifo_rd_count), PKT_LEN);
    emit_frame();
    enable = 1'b1;
    wait_drain(200, 1'b0);
    chk("t3b_frame_cnt", int'(frame_cnt), 5);

    // Test 4: reset mid-payload aborts the frame
    for (int i = 0; i < PKT_LEN; i++) push_byte(8'($urandom_range(0, 255)));
    emit_frame();
    acc_base = acc_cnt;
    wait_acc(acc_base, 10, 200);
    rstn = 1'b0;
    #1;
    chk("t4_rd_en_in_rst", int'(fifo_rd_en), 0);
    tick();
    chk("t4_valid_after_rst", int'(m_valid), 0);
    chk("t4_busy_after_rst", int'(busy), 0);
    chk("t4_frame_cnt_rst", int'(frame_cnt), 0);
    exp_q.delete();
    pend_q.delete();
    seq_m = 8'h00;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    rstn = 1'b1;
    tick();

    // Test 5: all-zero payload with seq 00, then 0x01 + zeros, back to back
    for (int i = 0; i < PKT_LEN; i++) push_byte(8'h00);
    push_byte(8'h01);
    for (int i = 1; i < PKT_LEN; i++) push_byte(8'h00);
    emit_frame();
    emit_frame();
    wait_drain(200, 1'b0);
    chk("t5_frame_cnt", int'(frame_cnt), 2);
    chk("t5_zero_csum", int'(csum_hist[csum_hist.size() - 2]), 0);
    chk("t5_one_csum", int'(csum_hist[csum_hist.size() - 1]), int'(last_exp_csum));
    chk("t5_run", last_run, PKT_LEN + 3);
    chk("t5_gap", last_gap, 1);
    chk("t5_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwft_byte_framer.md
Name: fwft_byte_framer

Overview:
- Downstream consumer of the 64-to-8 FWFT sync FIFO: pops bytes from the FIFO read side and emits fixed-length framed packets on a valid/ready byte stream.
- Frame = header byte, sequence byte, PKT_LEN payload bytes, checksum byte.
- Sits between the width-converting FIFO and the serial/transport stage.
- Starts a frame only when a full payload is buffered, so payload streams without FIFO-induced bubbles.

Parameters:
- PKT_LEN, 16, payload bytes per frame (2..255).
- HDR_BYTE, 8'hA5, constant first byte of every frame.
- CNT_W, 8, width of fifo_rd_count (= $clog2(RD_DEPTH)+1 for RD_DEPTH=128).

Ports:
- sys_clk  in  1  single clock; all logic on posedge.
- rstn  in  1  synchronous, active-low reset.
- enable  in  1  permits starting new frames.
- fifo_dout  in  8  FWFT head byte, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_count  in  CNT_W  FIFO read-side occupancy in bytes.
- fifo_rd_en  out  1  pop strobe; combinational.
- m_data  out  8  output byte.
- m_valid  out  1  m_data valid.
- m_last  out  1  high with checksum byte.
- m_ready  in  1  sink accepts when m_valid & m_ready.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  completed frames, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, m_data=0, m_valid=0, m_last=0, seq=0, csum=0, byte_idx=0, frame_cnt=0. fifo_rd_en is 0 while rstn=0.
- Output register: slot_free = !m_valid | m_ready. New bytes load only when slot_free; m_data/m_valid/m_last hold while m_valid & !m_ready.
- FSM:
  - IDLE -> HDR when enable & fifo_rd_count >= PKT_LEN & slot_free.
  - HDR: load HDR_BYTE when slot_free; -> SEQ.
  - SEQ: load seq; csum <= seq; -> PAY.
  - PAY: fifo_rd_en = !fifo_empty & slot_free. On a pop, load fifo_dout, csum += fifo_dout (mod 256), byte_idx++. After pop with byte_idx = PKT_LEN-1 -> CSUM; byte_idx <= 0.
  - CSUM: load csum, m_last=1; seq++ (mod 256); frame_cnt++; -> IDLE.
- Latency:
  - Popped byte appears on m_data one cycle after fifo_rd_en.
  - With m_ready held high, a frame is PKT_LEN+3 consecutive valid cycles; IDLE adds 1 cycle between frames.
- fifo_empty=1 in PAY: stall, no pop, m_valid drops after the held byte drains; no error.
- enable deasserted mid-frame: current frame completes; no new frame starts.
- Checksum: 8-bit sum of seq and payload bytes; header excluded.
- rstn low mid-frame: frame aborted, everything returns to reset values, seq restarts at 0.

Optional Feature:
- FRAMER_CRC8_EN defined: checksum byte is CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no xorout) over seq and payload, updated one byte per pop.
- Undefined: 8-bit additive sum as above.
- Frame length and timing are identical either way.

Decomposition:
- Package framer_pkg: state enum (IDLE, HDR, SEQ, PAY, CSUM), CRC8_POLY constant, crc8_byte function.
- One sub-module: framer_csum, an accumulator with clear/update/select-by-macro.
- FSM and output register stay in the top.

Test Plan:
- Preload 16 bytes 0x01..0x10, enable=1, m_ready=1 -> stream A5,00,01..10,88 with m_last on 88, frame_cnt=1, fifo_rd_en high 16 cycles.
- fifo_rd_count=15, enable=1 -> stays IDLE, m_valid=0, no pops.
- 32 bytes buffered, m_ready toggling 1/0 every cycle -> two intact frames with seq 00 then 01, no dropped or duplicated bytes, m_data stable while stalled.
- enable dropped at payload byte 5 -> frame finishes with correct checksum; no second frame although 16 bytes remain.
- rstn=0 at payload byte 8 -> next cycle m_valid=0 and busy=0; the next frame uses seq=00.
- FRAMER_CRC8_EN defined, payload all 0x00 with seq 00 -> checksum byte 0x00. Payload 0x01 then fifteen 0x00 -> checksum equals the reference-model CRC-8.
